bullet_manager: RTL

- Upstream feeder for the bullet sprite draw stage. It owns a pool of NUM_BULLETS bullet slots and spawns bullets on fire requests.
- On each frame tick, it advances every live bullet by SPEED pixels in that bullet's direction. Bullets that would leave the screen are retired.
- Per pixel, it reports whether (DrawX, DrawY) lies inside a live bullet, plus the 6-bit sprite ROM address (8x8 sprite) for the downstream ROM/palette stage.

---
 rtl/bullet_manager.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/bullet_manager.sv
// Bullet pool for the sprite draw stage: spawns bullets on fire, moves them on
// each frame tick, and reports per-pixel coverage plus the 8x8 sprite ROM index.
module bullet_manager #(
    parameter int NUM_BULLETS = 4,
    parameter int SPEED       = 4,
    parameter int SPR_DIM     = 8
) (
    input  logic                   vga_clk,
    input  logic                   reset_n,
    input  logic                   frame_tick,
    input  logic                   fire,
    input  logic [9:0]             fire_x,
    input  logic [9:0]             fire_y,
    input  logic [1:0]             fire_dir,
    input  logic [9:0]             DrawX,
    input  logic [9:0]             DrawY,
    output logic                   bullet_on,
    output logic [5:0]             rom_address,
    output logic [NUM_BULLETS-1:0] active,
    output logic                   fire_drop,
    output logic                   busy
);
    typedef enum logic {IDLE = 1'b0, UPDATE = 1'b1} state_t;

    localparam logic [10:0] SPD   = 11'(SPEED);
    localparam logic [10:0] X_MAX = 11'(640 - SPR_DIM);
    localparam logic [10:0] Y_MAX = 11'(480 - SPR_DIM);
    localparam logic [10:0] DIM   = 11'(SPR_DIM);

    state_t                 state_q, state_d;
    logic [2:0]             idx_q, idx_d;
    logic [9:0]             x_q [NUM_BULLETS];
    logic [9:0]             x_d [NUM_BULLETS];
    logic [9:0]             y_q [NUM_BULLETS];
    logic [9:0]             y_d [NUM_BULLETS];
    logic [1:0]             dir_q [NUM_BULLETS];
    logic [1:0]             dir_d [NUM_BULLETS];
    logic [NUM_BULLETS-1:0] active_q, active_d;
    logic                   pend_q, pend_d;
    logic [9:0]             pend_x_q, pend_x_d, pend_y_q, pend_y_d;
    logic [1:0]             pend_dir_q, pend_dir_d;
    logic                   fire_drop_q, fire_drop_d;
    logic                   busy_q, busy_d;
    logic                   bullet_on_q, bullet_on_d;
    logic [5:0]             rom_q, rom_d;

    logic                   spawn_s, found_s, hit_s;
    logic [9:0]             spawn_x_s, spawn_y_s;
    logic [1:0]             spawn_dir_s;
    logic [10:0]            cx_s, cy_s, px_s, py_s;

    // Next-state: FSM, spawn/pending handling, slot movement, pixel lookup
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        x_d         = x_q;
        y_d         = y_q;
        dir_d       = dir_q;
        active_d    = active_q;
        pend_d      = pend_q;
        pend_x_d    = pend_x_q;
        pend_y_d    = pend_y_q;
        pend_dir_d  = pend_dir_q;
        fire_drop_d = 1'b0;
        spawn_s     = 1'b0;
        spawn_x_s   = fire_x;
        spawn_y_s   = fire_y;
        spawn_dir_s = fire_dir;
        found_s     = 1'b0;
        hit_s       = 1'b0;
        bullet_on_d = 1'b0;
        rom_d       = 6'd0;
        cx_s        = 11'd0;
        cy_s        = 11'd0;
        px_s        = {1'b0, DrawX};
        py_s        = {1'b0, DrawY};

        // A pending fire is served first; a fresh fire in that cycle queues behind it
        if (state_q == IDLE) begin
            if (pend_q) begin
                spawn_s     = 1'b1;
                spawn_x_s   = pend_x_q;
                spawn_y_s   = pend_y_q;
                spawn_dir_s = pend_dir_q;
                pend_d      = fire;
                if (fire) begin
                    pend_x_d   = fire_x;
                    pend_y_d   = fire_y;
                    pend_dir_d = fire_dir;
                end else begin
                    pend_x_d   = pend_x_q;
                end
            end else begin
                spawn_s = fire;
            end
        end else begin
            if (fire) begin
                pend_d     = 1'b1;
                pend_x_d   = fire_x;
                pend_y_d   = fire_y;
                pend_dir_d = fire_dir;
            end else begin
                pend_d = pend_q;
            end
        end

        if (spawn_s) begin
            for (int i = 0; i < NUM_BULLETS; i++) begin
                if (!found_s && !active_q[i]) begin
                    found_s     = 1'b1;
                    active_d[i] = 1'b1;
                    x_d[i]      = spawn_x_s;
                    y_d[i]      = spawn_y_s;
                    dir_d[i]    = spawn_dir_s;
                end else begin
                    found_s = found_s;
                end
            end
            fire_drop_d = !found_s;
        end else begin
            fire_drop_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    state_d = UPDATE;
                    idx_d   = 3'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            UPDATE: begin
                for (int i = 0; i < NUM_BULLETS; i++) begin
                    if (idx_q == 3'(i) && active_q[i]) begin
                        cx_s = {1'b0, x_q[i]};
                        cy_s = {1'b0, y_q[i]};
                        case (dir_q[i])
                            2'd0: if (cy_s < SPD) active_d[i] = 1'b0;
                                  else y_d[i] = 10'(cy_s - SPD);
                            2'd1: if (cx_s + SPD > X_MAX) active_d[i] = 1'b0;
                                  else x_d[i] = 10'(cx_s + SPD);
                            2'd2: if (cy_s + SPD > Y_MAX) active_d[i] = 1'b0;
                                  else y_d[i] = 10'(cy_s + SPD);
                            2'd3: if (cx_s < SPD) active_d[i] = 1'b0;
                                  else x_d[i] = 10'(cx_s - SPD);
                            default: active_d[i] = 1'b0;
                        endcase
                    end else begin
                        active_d[i] = active_d[i];
                    end
                end
                if (idx_q == 3'(NUM_BULLETS - 1)) begin
                    state_d = IDLE;
                    idx_d   = 3'd0;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = 3'd0;
            end
        endcase

        busy_d = (state_d == UPDATE);

        // Lowest-index hit wins; offsets are < 8 so 3-bit differences suffice
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (!hit_s && active_q[i]
                && px_s >= {1'b0, x_q[i]} && px_s < {1'b0, x_q[i]} + DIM
                && py_s >= {1'b0, y_q[i]} && py_s < {1'b0, y_q[i]} + DIM) begin
                hit_s       = 1'b1;
                bullet_on_d = 1'b1;
                rom_d       = {DrawY[2:0] - y_q[i][2:0], DrawX[2:0] - x_q[i][2:0]};
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            active_q    <= '0;
            pend_q      <= 1'b0;
            pend_x_q    <= 10'd0;
            pend_y_q    <= 10'd0;
            pend_dir_q  <= 2'd0;
            fire_drop_q <= 1'b0;
            busy_q      <= 1'b0;
            bullet_on_q <= 1'b0;
            rom_q       <= 6'd0;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                x_q[i]   <= 10'd0;
                y_q[i]   <= 10'd0;
                dir_q[i] <= 2'd0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            active_q    <= active_d;
            pend_q      <= pend_d;
            pend_x_q    <= pend_x_d;
            pend_y_q    <= pend_y_d;
            pend_dir_q  <= pend_dir_d;
            fire_drop_q <= fire_drop_d;
            busy_q      <= busy_d;
            bullet_on_q <= bullet_on_d;
            rom_q       <= rom_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dir_q       <= dir_d;
        end
    end

    assign bullet_on   = bullet_on_q;
    assign rom_address = rom_q;
    assign active      = active_q;
    assign fire_drop   = fire_drop_q;
    assign busy        = busy_q;
endmodule
